rv_mc_ctrl: RTL and testbench

RV_MC_CTRL -- requirements
Module: rv_mc_ctrl

---
 rtl/rv_mc_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_rv_mc_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mc_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : rv_mc_ctrl
// Brief    : Multi-cycle RV32I control FSM sequencing fetch, decode, execute,
//            memory and write-back, with illegal-opcode and memory-timeout traps.
// Revision : 1.0 - initial release
// =============================================================================
module rv_mc_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic       rf_we,
    output logic [2:0] imm_sel,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] pc_sel,
    output logic [1:0] wb_sel,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    state_t     state;
    logic [6:0] opc;
    logic [7:0] wait_cnt;
    logic [1:0] cause;

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_opimm, is_op, is_legal;

    assign is_lui    = (opc == OPC_LUI);
    assign is_auipc  = (opc == OPC_AUIPC);
    assign is_jal    = (opc == OPC_JAL);
    assign is_jalr   = (opc == OPC_JALR);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_opimm  = (opc == OPC_OPIMM);
    assign is_op     = (opc == OPC_OP);
    assign is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                       is_load | is_store | is_opimm | is_op;

    // The wait counter only advances while stalled in FETCH/MEM; every exit
    // from those states zeroes it, so it is always clear on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            opc      <= 7'd0;
            wait_cnt <= 8'd0;
            cause    <= 2'b00;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        opc      <= opcode;
                        wait_cnt <= 8'd0;
                        state    <= ST_DECODE;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        wait_cnt <= 8'd0;
                        cause    <= CAUSE_TIMEOUT;
                        state    <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DECODE: begin
                    if (is_legal) begin
                        state <= ST_EXEC;
                    end else begin
                        cause <= CAUSE_ILLEGAL;
                        state <= ST_TRAP;
                    end
                end
                ST_EXEC: begin
                    if (is_branch || is_jal || is_jalr) begin
                        state <= ST_FETCH;
                    end else if (is_load || is_store) begin
                        state <= ST_MEM;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        wait_cnt <= 8'd0;
                        state    <= is_load ? ST_WB : ST_FETCH;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        wait_cnt <= 8'd0;
                        cause    <= CAUSE_TIMEOUT;
                        state    <= ST_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_WB: begin
                    state <= ST_FETCH;
                end
                ST_TRAP: begin
                    state <= ST_TRAP;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    assign trap       = (state == ST_TRAP);
    assign trap_cause = cause;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        imm_sel   = 3'b000;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        pc_sel    = 2'b00;
        wb_sel    = 2'b00;

        if (state == ST_DECODE || state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
            if (is_lui || is_auipc) begin
                imm_sel = 3'b011;
            end else if (is_jal) begin
                imm_sel = 3'b100;
            end else if (is_branch) begin
                imm_sel = 3'b010;
            end else if (is_store) begin
                imm_sel = 3'b001;
            end
        end

        unique case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_EXEC: begin
                alu_src_a = is_auipc;
                alu_src_b = ~(is_op | is_branch);
                if (is_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? 2'b01 : 2'b00;
                end else if (is_jal || is_jalr) begin
                    rf_we  = 1'b1;
                    wb_sel = 2'b10;
                    pc_we  = 1'b1;
                    pc_sel = is_jal ? 2'b01 : 2'b10;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                pc_we   = is_store & mem_ready;
            end
            ST_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                wb_sel = is_load ? 2'b01 : (is_lui ? 2'b11 : 2'b00);
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_mc_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_rv_mc_ctrl
// Brief    : Self-checking bench for rv_mc_ctrl; directed cases then a random
//            instruction stream compared against a per-instruction reference.
// Revision : 1.0 - initial release
// =============================================================================
module tb_rv_mc_ctrl;

    localparam int TB_TIMEOUT = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;
    logic       mem_req, mem_we, ir_we, pc_we, rf_we;
    logic [2:0] imm_sel;
    logic       alu_src_a, alu_src_b;
    logic [1:0] pc_sel, wb_sel;
    logic       trap;
    logic [1:0] trap_cause;

    always #5 clk = ~clk;

    rv_mc_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .imm_sel      (imm_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .pc_sel       (pc_sel),
        .wb_sel       (wb_sel),
        .trap         (trap),
        .trap_cause   (trap_cause)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       ir_we;
        logic       pc_we;
        logic       rf_we;
        logic [2:0] imm_sel;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] pc_sel;
        logic [1:0] wb_sel;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    outs_t obs;
    assign obs = {mem_req, mem_we, ir_we, pc_we, rf_we, imm_sel, alu_src_a,
                  alu_src_b, pc_sel, wb_sel, trap, trap_cause};

    int n_checks = 0;
    int n_errors = 0;
    int trap_len = 3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC: return 3'b011;
            OPC_JAL:            return 3'b100;
            OPC_BRANCH:         return 3'b010;
            OPC_STORE:          return 3'b001;
            default:            return 3'b000;
        endcase
    endfunction

    function automatic logic [6:0] pick_legal(input int i);
        case (i)
            0:       return OPC_LUI;
            1:       return OPC_AUIPC;
            2:       return OPC_JAL;
            3:       return OPC_JALR;
            4:       return OPC_BRANCH;
            5:       return OPC_LOAD;
            6:       return OPC_STORE;
            7:       return OPC_OPIMM;
            default: return OPC_OP;
        endcase
    endfunction

    // One clock cycle: drive inputs at the falling edge, check just after.
    task automatic cyc(input bit ready, input logic [6:0] op, input bit taken,
                       input outs_t e, input string tag);
        @(negedge clk);
        mem_ready    = ready;
        opcode       = op;
        branch_taken = taken;
        #1;
        check(tag, 32'(obs), 32'(e));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'($urandom);
        opcode    = 7'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic trap_hold(input logic [1:0] cause);
        outs_t e;
        for (int n = 0; n < trap_len; n++) begin
            e            = '0;
            e.trap       = 1'b1;
            e.trap_cause = cause;
            cyc(1'($urandom), 7'($urandom), 1'($urandom), e, "trap");
        end
    endtask

    // Reference for one instruction: fw / mw are the cycles of mem_ready=0
    // before the accepting cycle in fetch / memory access.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input bit taken, input bit rst_in_mem);
        outs_t e;
        for (int k = 0; k <= TB_TIMEOUT; k++) begin
            e         = '0;
            e.mem_req = 1'b1;
            e.ir_we   = (k == fw);
            cyc(k == fw, (k == fw) ? op : 7'($urandom), 1'($urandom), e, "fetch");
            if (k == fw) break;
        end
        if (fw > TB_TIMEOUT) begin
            trap_hold(2'b10);
            do_reset();
            return;
        end

        e         = '0;
        e.imm_sel = imm_of(op);
        cyc(1'($urandom), 7'($urandom), 1'($urandom), e, "decode");
        if (!is_legal(op)) begin
            trap_hold(2'b01);
            do_reset();
            return;
        end

        e.alu_src_a = (op == OPC_AUIPC);
        e.alu_src_b = !(op == OPC_OP || op == OPC_BRANCH);
        if (op == OPC_BRANCH) begin
            e.pc_we  = 1'b1;
            e.pc_sel = taken ? 2'b01 : 2'b00;
        end else if (op == OPC_JAL || op == OPC_JALR) begin
            e.rf_we  = 1'b1;
            e.wb_sel = 2'b10;
            e.pc_we  = 1'b1;
            e.pc_sel = (op == OPC_JAL) ? 2'b01 : 2'b10;
        end
        cyc(1'($urandom), 7'($urandom), taken, e, "exec");
        if (op == OPC_BRANCH || op == OPC_JAL || op == OPC_JALR) return;

        if (op == OPC_LOAD || op == OPC_STORE) begin
            for (int k = 0; k <= TB_TIMEOUT; k++) begin
                if (rst_in_mem && k == 2) begin
                    do_reset();
                    e         = '0;
                    e.mem_req = 1'b1;
                    cyc(1'b0, 7'($urandom), 1'($urandom), e, "rst_mem");
                    do_reset();
                    return;
                end
                e         = '0;
                e.mem_req = 1'b1;
                e.mem_we  = (op == OPC_STORE);
                e.imm_sel = imm_of(op);
                e.pc_we   = (op == OPC_STORE) && (k == mw);
                cyc(k == mw, 7'($urandom), 1'($urandom), e, "mem");
                if (k == mw) break;
            end
            if (mw > TB_TIMEOUT) begin
                trap_hold(2'b10);
                do_reset();
                return;
            end
            if (op == OPC_STORE) return;
        end

        e         = '0;
        e.imm_sel = imm_of(op);
        e.rf_we   = 1'b1;
        e.pc_we   = 1'b1;
        e.wb_sel  = (op == OPC_LOAD) ? 2'b01 : ((op == OPC_LUI) ? 2'b11 : 2'b00);
        cyc(1'($urandom), 7'($urandom), 1'($urandom), e, "wb");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        outs_t e;
        logic [6:0] op;
        int fw, mw;

        rst          = 1'b1;
        mem_ready    = 1'b0;
        opcode       = 7'd0;
        branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        e         = '0;
        e.mem_req = 1'b1;
        cyc(1'b0, 7'($urandom), 1'b0, e, "reset");
        do_reset();

        run_instr(OPC_OP, 0, 0, 1'b0, 1'b0);
        run_instr(OPC_LOAD, 0, 3, 1'b0, 1'b0);
        run_instr(OPC_BRANCH, 1, 0, 1'b1, 1'b0);
        run_instr(OPC_BRANCH, 0, 0, 1'b0, 1'b0);
        trap_len = 10;
        run_instr(7'b0000000, 0, 0, 1'b0, 1'b0);
        trap_len = 3;
        run_instr(OPC_OP, TB_TIMEOUT + 1, 0, 1'b0, 1'b0);
        run_instr(OPC_OP, TB_TIMEOUT, 0, 1'b0, 1'b0);
        run_instr(OPC_STORE, 0, 5, 1'b0, 1'b1);
        run_instr(OPC_STORE, 0, TB_TIMEOUT, 1'b0, 1'b0);
        run_instr(OPC_LOAD, 0, TB_TIMEOUT + 1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            run_instr(pick_legal(i), 0, 1, 1'($urandom), 1'b0);
        end

        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pick_legal($urandom_range(0, 8));
            fw = ($urandom_range(0, 19) == 0) ? TB_TIMEOUT + 1 : $urandom_range(0, TB_TIMEOUT);
            mw = ($urandom_range(0, 19) == 0) ? TB_TIMEOUT + 1 : $urandom_range(0, TB_TIMEOUT);
            run_instr(op, fw, mw, 1'($urandom), ($urandom_range(0, 29) == 0) && (mw >= 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
